// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: single-master bus controller. It latches a CPU request,
// decodes the address into one of four targets, runs a request/ack
// handshake and returns a one-cycle completion pulse.
// Optional feature: define MEM_BUS_CTRL_TIMEOUT_EN to bound the ACCESS
// state with a TIMEOUT_CYCLES watchdog that ends in a bus error.
module mem_bus_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic [3:0]    cpu_wstrb,
    output logic          cpu_ready,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_err,
    output logic [31:0]   dec_addr,
    input  logic          sel_bram,
    input  logic          sel_sram,
    input  logic          sel_flash,
    input  logic          sel_periph,
    input  logic          sel_err,
    output logic [3:0]    tgt_req,
    output logic          tgt_we,
    output logic [31:0]   tgt_addr,
    output logic [31:0]   tgt_wdata,
    output logic [3:0]    tgt_wstrb,
    input  logic [3:0]    tgt_ack,
    input  logic [127:0]  tgt_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        ACCESS = 3'd2,
        RESP   = 3'd3,
        ERR    = 3'd4
    } state_t;

    state_t       state_q, state_d;
    logic         we_q, we_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  wdata_q, wdata_d;
    logic [3:0]   wstrb_q, wstrb_d;
    logic [1:0]   idx_q, idx_d;
    logic [31:0]  rdata_q, rdata_d;

    // Decoder selects gathered in target order so bit n matches tgt_req[n].
    logic [3:0]   sel_vec;
    logic [2:0]   sel_cnt;
    logic [1:0]   sel_idx;
    logic         ack_hit;

`ifdef MEM_BUS_CTRL_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]   tmo_cnt_q, tmo_cnt_d;
`endif

    assign sel_vec = {sel_periph, sel_flash, sel_sram, sel_bram};

    // Latched request fields are visible to the decoder and targets at all times.
    assign dec_addr  = addr_q;
    assign tgt_addr  = addr_q;
    assign tgt_we    = we_q;
    assign tgt_wdata = wdata_q;
    assign tgt_wstrb = wstrb_q;

    // Only the ack of the recorded target can complete an access.
    assign ack_hit = tgt_ack[idx_q];

    // Count active selects and pick the index of the (hopefully single) one.
    always_comb begin
        sel_cnt = '0;
        sel_idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (sel_vec[i]) begin
                sel_cnt = sel_cnt + 3'd1;
                sel_idx = 2'(i);
            end
        end
    end

    // Next-state logic and Moore outputs.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        idx_d     = idx_q;
        rdata_d   = rdata_q;
        cpu_ready = 1'b0;
        cpu_err   = 1'b0;
        cpu_rdata = '0;
        tgt_req   = '0;
`ifdef MEM_BUS_CTRL_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    wstrb_d = cpu_wstrb;
                    state_d = DECODE;
                end
            end
            DECODE: begin
`ifdef MEM_BUS_CTRL_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
                if (!sel_err && sel_cnt == 3'd1) begin
                    idx_d   = sel_idx;
                    state_d = ACCESS;
                end else begin
                    state_d = ERR;
                end
            end
            ACCESS: begin
                tgt_req[idx_q] = 1'b1;
                if (ack_hit) begin
                    rdata_d = we_q ? 32'h0 : tgt_rdata[32*idx_q +: 32];
                    state_d = RESP;
                end
`ifdef MEM_BUS_CTRL_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = ERR;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
`endif
            end
            RESP: begin
                cpu_ready = 1'b1;
                cpu_rdata = rdata_q;
                state_d   = IDLE;
            end
            ERR: begin
                cpu_ready = 1'b1;
                cpu_err   = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched-field registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            idx_q   <= '0;
            rdata_q <= '0;
`ifdef MEM_BUS_CTRL_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
`ifdef MEM_BUS_CTRL_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed testbench for mem_bus_ctrl with a behavioural address decoder.
// Timeout scenarios are exercised only when MEM_BUS_CTRL_TIMEOUT_EN is defined.
module tb_mem_bus_ctrl;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req;
    logic          cpu_we;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [3:0]    cpu_wstrb;
    logic          cpu_ready;
    logic [31:0]   cpu_rdata;
    logic          cpu_err;
    logic [31:0]   dec_addr;
    logic          sel_bram, sel_sram, sel_flash, sel_periph, sel_err;
    logic [3:0]    tgt_req;
    logic          tgt_we;
    logic [31:0]   tgt_addr;
    logic [31:0]   tgt_wdata;
    logic [3:0]    tgt_wstrb;
    logic [3:0]    tgt_ack;
    logic [127:0]  tgt_rdata;
    logic          force_multi;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_bus_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dec_addr(dec_addr),
        .sel_bram(sel_bram), .sel_sram(sel_sram), .sel_flash(sel_flash),
        .sel_periph(sel_periph), .sel_err(sel_err),
        .tgt_req(tgt_req), .tgt_we(tgt_we), .tgt_addr(tgt_addr),
        .tgt_wdata(tgt_wdata), .tgt_wstrb(tgt_wstrb),
        .tgt_ack(tgt_ack), .tgt_rdata(tgt_rdata)
    );

    // Address map: 64 KiB windows at 0x0000/0x0001/0x0002/0x0003_xxxx, rest is a hole.
    always_comb begin
        sel_bram   = (dec_addr[31:16] == 16'h0000);
        sel_sram   = (dec_addr[31:16] == 16'h0001) || force_multi;
        sel_flash  = (dec_addr[31:16] == 16'h0002);
        sel_periph = (dec_addr[31:16] == 16'h0003);
        sel_err    = (dec_addr[31:16] > 16'h0003);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns 1ns after the sampling edge (DECODE).
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_wstrb = wstrb;
        tick();
        cpu_req   = 1'b0;
        cpu_addr  = 32'hFFFF_FFFF;
        cpu_wdata = 32'h0BAD_0BAD;
        chk("decode_ready", {31'd0, cpu_ready}, 32'd0);
        chk("decode_dec_addr", dec_addr, addr);
    endtask

    // Plain bram read acked in the first ACCESS cycle.
    task automatic bram_read(input string name, input logic [31:0] addr, input logic [31:0] data);
        issue(1'b0, addr, 32'h0, 4'h0);
        tick();
        chk({name, "_req"}, {28'd0, tgt_req}, 32'h1);
        tgt_ack = 4'b0001;
        tgt_rdata[31:0] = data;
        tick();
        tgt_ack = 4'b0000;
        chk({name, "_ready"}, {31'd0, cpu_ready}, 32'd1);
        chk({name, "_err"}, {31'd0, cpu_err}, 32'd0);
        chk({name, "_rdata"}, cpu_rdata, data);
        chk({name, "_req_drop"}, {28'd0, tgt_req}, 32'h0);
        tick();
        chk({name, "_ready_end"}, {31'd0, cpu_ready}, 32'd0);
        $display("txn %s addr=%h rdata=%h", name, addr, cpu_rdata);
    endtask

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0;
        cpu_wdata = 32'h0; cpu_wstrb = 4'h0; tgt_ack = 4'h0;
        tgt_rdata = '0; force_multi = 1'b0;
        tick(); tick();
        chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
        chk("rst_err", {31'd0, cpu_err}, 32'd0);
        chk("rst_req", {28'd0, tgt_req}, 32'h0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_dec_addr", dec_addr, 32'h0);
        rst = 1'b0;
        // ack while IDLE must not matter
        tgt_ack = 4'b1111;
        tick();
        tgt_ack = 4'b0000;
        chk("idle_ack_ready", {31'd0, cpu_ready}, 32'd0);

        // Basic bram read, ack in first ACCESS cycle.
        bram_read("rd_bram", 32'h0000_0010, 32'hDEAD_BEEF);

        // sram write with 3 wait cycles.
        tgt_rdata[63:32] = 32'h5555_AAAA;
        issue(1'b1, 32'h0001_0004, 32'h1234_5678, 4'b0011);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wr_req", {28'd0, tgt_req}, 32'h2);
            chk("wr_we", {31'd0, tgt_we}, 32'd1);
            chk("wr_addr", tgt_addr, 32'h0001_0004);
            chk("wr_wdata", tgt_wdata, 32'h1234_5678);
            chk("wr_wstrb", {28'd0, tgt_wstrb}, 32'h3);
            chk("wr_wait_ready", {31'd0, cpu_ready}, 32'd0);
            if (i == 3) tgt_ack = 4'b0010;
        end
        tick();
        tgt_ack = 4'b0000;
        chk("wr_ready", {31'd0, cpu_ready}, 32'd1);
        chk("wr_err", {31'd0, cpu_err}, 32'd0);
        chk("wr_rdata", cpu_rdata, 32'h0);
        chk("wr_req_drop", {28'd0, tgt_req}, 32'h0);
        tick();
        $display("txn wr_sram addr=00010004 wdata=12345678");

        // Decoder hole -> bus error, ready in 3rd cycle counting the request cycle.
        issue(1'b0, 32'h0005_0000, 32'h0, 4'h0);
        chk("hole_req_dec", {28'd0, tgt_req}, 32'h0);
        tick();
        chk("hole_ready", {31'd0, cpu_ready}, 32'd1);
        chk("hole_err", {31'd0, cpu_err}, 32'd1);
        chk("hole_rdata", cpu_rdata, 32'h0);
        chk("hole_req", {28'd0, tgt_req}, 32'h0);
        tick();
        chk("hole_ready_end", {31'd0, cpu_ready}, 32'd0);
        $display("txn hole addr=00050000 err=1");

        // Two selects high -> bus error.
        force_multi = 1'b1;
        issue(1'b0, 32'h0000_0100, 32'h0, 4'h0);
        tick();
        force_multi = 1'b0;
        chk("multi_ready", {31'd0, cpu_ready}, 32'd1);
        chk("multi_err", {31'd0, cpu_err}, 32'd1);
        chk("multi_req", {28'd0, tgt_req}, 32'h0);
        tick();
        $display("txn multi_sel err=1");

        // Stray ack from flash and cpu_req toggling during a bram access.
        tgt_rdata[95:64] = 32'h7777_7777;
        issue(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        tick();
        tgt_ack = 4'b0100;
        cpu_req = 1'b1; cpu_addr = 32'h0002_0000; cpu_we = 1'b1;
        tick();
        chk("stray_req", {28'd0, tgt_req}, 32'h1);
        chk("stray_ready", {31'd0, cpu_ready}, 32'd0);
        chk("stray_dec_addr", dec_addr, 32'h0000_0020);
        chk("stray_we", {31'd0, tgt_we}, 32'd0);
        cpu_req = 1'b0;
        tgt_ack = 4'b0001;
        tgt_rdata[31:0] = 32'hCAFE_0001;
        tick();
        tgt_ack = 4'b0000;
        chk("stray_done_ready", {31'd0, cpu_ready}, 32'd1);
        chk("stray_done_rdata", cpu_rdata, 32'hCAFE_0001);
        tick();
        chk("stray_single", {31'd0, cpu_ready}, 32'd0);
        tick();
        chk("stray_single2", {31'd0, cpu_ready}, 32'd0);
        $display("txn stray_ack rdata=cafe0001");

        // Reset during a flash access aborts silently.
        issue(1'b0, 32'h0002_0000, 32'h0, 4'h0);
        tick();
        chk("rstacc_req_pre", {28'd0, tgt_req}, 32'h4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstacc_req", {28'd0, tgt_req}, 32'h0);
        chk("rstacc_dec_addr", dec_addr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("rstacc_noready", {31'd0, cpu_ready}, 32'd0);
            tick();
        end
        $display("txn flash_reset aborted");
        bram_read("rd_after_rst", 32'h0000_0040, 32'h0F0F_1234);

`ifdef MEM_BUS_CTRL_TIMEOUT_EN
        // Peripheral never acks: 16 ACCESS cycles then ERR.
        issue(1'b0, 32'h0003_0000, 32'h0, 4'h0);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("tmo_req", {28'd0, tgt_req}, 32'h8);
        end
        tick();
        chk("tmo_ready", {31'd0, cpu_ready}, 32'd1);
        chk("tmo_err", {31'd0, cpu_err}, 32'd1);
        chk("tmo_req_drop", {28'd0, tgt_req}, 32'h0);
        tick();
        $display("txn periph_timeout err=1");
        // Ack on the 16th cycle wins.
        tgt_rdata[127:96] = 32'hA5A5_0016;
        issue(1'b0, 32'h0003_0008, 32'h0, 4'h0);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("tmo16_req", {28'd0, tgt_req}, 32'h8);
            if (i == 15) tgt_ack = 4'b1000;
        end
        tick();
        tgt_ack = 4'b0000;
        chk("tmo16_ready", {31'd0, cpu_ready}, 32'd1);
        chk("tmo16_err", {31'd0, cpu_err}, 32'd0);
        chk("tmo16_rdata", cpu_rdata, 32'hA5A5_0016);
        tick();
        $display("txn periph_ack16 rdata=a5a50016");
`else
        // Without the watchdog a slow peripheral is waited on indefinitely.
        tgt_rdata[127:96] = 32'hA5A5_0030;
        issue(1'b0, 32'h0003_0008, 32'h0, 4'h0);
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("slow_req", {28'd0, tgt_req}, 32'h8);
            chk("slow_noready", {31'd0, cpu_ready}, 32'd0);
            if (i == 29) tgt_ack = 4'b1000;
        end
        tick();
        tgt_ack = 4'b0000;
        chk("slow_ready", {31'd0, cpu_ready}, 32'd1);
        chk("slow_err", {31'd0, cpu_err}, 32'd0);
        chk("slow_rdata", cpu_rdata, 32'hA5A5_0030);
        tick();
        $display("txn periph_slow rdata=a5a50030");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
